// File: rtl/d_sram_bridge.sv
// Data-side bridge: turns the core's single-cycle memory-stage access into one
// req/addr_ok/data_ok bus transaction and stalls the pipeline until it completes.
module d_sram_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_en,
    input  logic [1:0]    mem_size,
    input  logic [3:0]    memwrite,
    input  logic [AW-1:0] aluout,
    input  logic [DW-1:0] writedata,
    input  logic          ext_stall,
    output logic [DW-1:0] readdata,
    output logic          mem_stall,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [DW-1:0] rdata_q;
    logic          latch;
    logic          capture;
    logic [1:0]    size_sel;

    // Bus size derived from the store byte-enable pattern.
    function automatic logic [1:0] store_size(input logic [3:0] be);
        case (be)
            4'b1111:                             store_size = 2'd2;
            4'b0011, 4'b1100:                    store_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000:  store_size = 2'd0;
            default:                             store_size = 2'd2;
        endcase
    endfunction

    // Access size selection: store sizes from byte enables, load size 3 folds to word.
    always_comb begin
        size_sel = 2'd2;
        if (|memwrite)
            size_sel = store_size(memwrite);
        else if (mem_size != 2'd3)
            size_sel = mem_size;
    end

    // Next-state logic plus latch/capture strobes for the datapath registers.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    latch   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (data_addr_ok && data_data_ok) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (data_addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (data_data_ok) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!ext_stall)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request payload is latched once in IDLE and held through REQ/WAIT/DONE;
    // read data is captured only for loads and survives until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (latch) begin
                addr_q  <= aluout;
                wdata_q <= writedata;
                wr_q    <= |memwrite;
                size_q  <= size_sel;
            end
            if (capture && !wr_q)
                rdata_q <= data_rdata;
        end
    end

    assign data_req   = (state_q == REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign readdata   = rdata_q;
    assign mem_stall  = mem_en & (state_q != DONE);

endmodule

// File: tb/tb_d_sram_bridge.sv
// Scoreboard bench for d_sram_bridge: directed accesses push expected bus
// requests and load results; a negedge monitor pops and compares them.
module tb_d_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [1:0]  mem_size;
    logic [3:0]  memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic        ext_stall;
    logic [31:0] readdata;
    logic        mem_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    d_sram_bridge #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_size(mem_size),
        .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .ext_stall(ext_stall), .readdata(readdata), .mem_stall(mem_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          ncyc;
        int          gap;
    } req_t;

    typedef struct {
        logic [31:0] rd;
        int          ndone;
    } rd_t;

    req_t req_q[$];
    rd_t  rd_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [31:0] exp_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks request payload and length, DONE behaviour and held read data.
    int reqcnt  = 0;
    int donecnt = 0;
    int last_done = -100;
    always @(negedge clk) begin
        if (data_req) begin
            reqcnt++;
            if (req_q.size() == 0) begin
                chk("unexpected_req", 32'd1, 32'd0);
            end else begin
                if (reqcnt == 1 && req_q[0].gap >= 0)
                    chk("req_gap", cyc - last_done, req_q[0].gap);
                chk("req_addr", data_addr, req_q[0].addr);
                chk("req_wr", {31'd0, data_wr}, {31'd0, req_q[0].wr});
                chk("req_size", {30'd0, data_size}, {30'd0, req_q[0].size});
                if (req_q[0].wr)
                    chk("req_wdata", data_wdata, req_q[0].wdata);
                if (data_addr_ok) begin
                    chk("req_cycles", reqcnt, req_q[0].ncyc);
                    void'(req_q.pop_front());
                    reqcnt = 0;
                end
            end
        end
        if (rst && mem_en && !mem_stall) begin
            donecnt++;
            chk("done_no_req", {31'd0, data_req}, 32'd0);
            if (rd_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("readdata", readdata, rd_q[0].rd);
                if (!ext_stall) begin
                    chk("done_cycles", donecnt, rd_q[0].ndone);
                    void'(rd_q.pop_front());
                    donecnt   = 0;
                    last_done = cyc;
                end
            end
        end
    end

    // One access; ao = REQ cycles before addr_ok, dk = cycles from addr_ok to
    // data_ok (0 = same cycle), xs = ext_stall cycles held in DONE.
    task automatic access(input logic [1:0] sz, input logic [3:0] mw,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [1:0] exp_sz,
                          input int ao, input int dk, input int xs, input int gap);
        req_t r;
        rd_t  e;
        r.addr = a; r.wr = (mw != 4'b0000); r.size = exp_sz; r.wdata = wd;
        r.ncyc = ao + 1; r.gap = gap;
        req_q.push_back(r);
        if (mw == 4'b0000) exp_rd = rd;
        e.rd = exp_rd; e.ndone = xs + 1;
        rd_q.push_back(e);
        mem_en = 1'b1; mem_size = sz; memwrite = mw; aluout = a; writedata = wd;
        @(posedge clk); #1;
        chk("stall_in_req", {31'd0, mem_stall}, 32'd1);
        repeat (ao) begin @(posedge clk); #1; end
        data_addr_ok = 1'b1;
        if (dk == 0) begin
            data_data_ok = 1'b1; data_rdata = rd; ext_stall = (xs > 0);
        end
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h5555_5555;
        if (dk > 0) begin
            repeat (dk - 1) begin @(posedge clk); #1; end
            data_data_ok = 1'b1; data_rdata = rd; ext_stall = (xs > 0);
            @(posedge clk); #1;
            data_data_ok = 1'b0; data_rdata = 32'h5555_5555;
        end
        repeat (xs) begin @(posedge clk); #1; end
        ext_stall = 1'b0;
        @(posedge clk); #1;
        mem_en = 1'b0; memwrite = 4'b0000;
    endtask

    initial begin
        rst = 1'b0; mem_en = 1'b1; mem_size = 2'd0; memwrite = 4'b0000;
        aluout = '0; writedata = '0; ext_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        exp_rd = 32'h0;
        #12;
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_stall_en1", {31'd0, mem_stall}, 32'd1);
        mem_en = 1'b0; #1;
        chk("rst_stall_en0", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // load word, addr_ok on 2nd REQ cycle, data_ok 3 cycles later
        access(2'd2, 4'b0000, 32'h1000, 32'h0, 32'hDEADBEEF, 2'd2, 1, 3, 0, -1);
        // store byte, addr_ok+data_ok together, readdata unchanged
        access(2'd0, 4'b0100, 32'h2002, 32'h00AB0000, 32'h11111111, 2'd0, 0, 0, 0, -1);
        // store size patterns
        access(2'd0, 4'b1100, 32'h3002, 32'h12340000, 32'h22222222, 2'd1, 0, 0, 0, -1);
        access(2'd0, 4'b1111, 32'h3004, 32'hCAFEF00D, 32'h33333333, 2'd2, 0, 1, 0, -1);
        access(2'd0, 4'b0011, 32'h3008, 32'h00005678, 32'h44444444, 2'd1, 2, 0, 0, -1);
        access(2'd0, 4'b0101, 32'h300C, 32'h00990077, 32'h66666666, 2'd2, 0, 0, 0, -1);
        // load half with ext_stall held 4 cycles in DONE
        access(2'd1, 4'b0000, 32'h4002, 32'h0, 32'h0000CAFE, 2'd1, 0, 1, 4, -1);
        // load with size 3 folds to word
        access(2'd3, 4'b0000, 32'h4008, 32'h0, 32'h89ABCDEF, 2'd2, 0, 0, 0, -1);
        // back-to-back loads: one IDLE bubble before the second REQ
        access(2'd2, 4'b0000, 32'h10, 32'h0, 32'h01020304, 2'd2, 0, 1, 0, -1);
        access(2'd2, 4'b0000, 32'h14, 32'h0, 32'h05060708, 2'd2, 1, 0, 0, 2);

        // reset while in WAIT
        begin
            req_t r;
            r.addr = 32'h50; r.wr = 1'b0; r.size = 2'd2; r.wdata = '0;
            r.ncyc = 1; r.gap = -1;
            req_q.push_back(r);
        end
        mem_en = 1'b1; mem_size = 2'd2; memwrite = 4'b0000; aluout = 32'h50;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        chk("wait_req_low", {31'd0, data_req}, 32'd0);
        rst = 1'b0; #1;
        chk("rst_mid_req", {31'd0, data_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, mem_stall}, 32'd1);
        mem_en = 1'b0; exp_rd = 32'h0;
        @(posedge clk); #1; rst = 1'b1;
        data_data_ok = 1'b1; data_rdata = 32'h12345678;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(posedge clk); #1;
        chk("late_dok_readdata", readdata, 32'h0);
        chk("late_dok_req", {31'd0, data_req}, 32'd0);

        // normal load after reset
        access(2'd2, 4'b0000, 32'h60, 32'h0, 32'hA5A5A5A5, 2'd2, 0, 0, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("final_readdata", readdata, 32'hA5A5A5A5);
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("rd_q_empty", rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
